// File: rtl/bcd_counter_if.sv
// Handshake/data bundle between a bcd_counter and its controller.
// Digit 0 sits in [3:0] of both load_val and count.
interface bcd_counter_if #(
    parameter int unsigned DIGITS = 2
);
    logic                  en;
    logic                  up;
    logic                  load;
    logic [4*DIGITS-1:0]   load_val;
    logic [4*DIGITS-1:0]   count;
    logic                  wrap;
    logic                  load_err;
    logic                  tc;

    modport master (
        output en, up, load, load_val,
        input  count, wrap, load_err, tc
    );

    modport slave (
        input  en, up, load, load_val,
        output count, wrap, load_err, tc
    );
endinterface

// File: rtl/bcd_counter.sv
// Multi-digit BCD up/down counter with validated parallel load, wrap and
// load-error pulses, and a combinational terminal count for cascading.
// Digits are stepped per 4-bit slice with explicit 9/0 compares, so count
// never holds a non-BCD code.
module bcd_counter #(
    parameter int unsigned DIGITS = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    bcd_counter_if.slave   bus
);
    localparam int unsigned W = 4 * DIGITS;

    logic [W-1:0] count_q;
    logic         wrap_q;
    logic         load_err_q;

    logic [W-1:0] inc_val;
    logic [W-1:0] dec_val;
    logic         load_ok;
    logic         all_nines;
    logic         all_zero;
    logic         carry;
    logic         borrow;
    logic [3:0]   digit;

    // Next-value candidates: ripple increment/decrement and load digit check.
    always_comb begin
        inc_val   = count_q;
        dec_val   = count_q;
        load_ok   = 1'b1;
        all_nines = 1'b1;
        all_zero  = 1'b1;
        carry     = 1'b1;
        borrow    = 1'b1;
        digit     = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            digit = count_q[4*i +: 4];
            if (digit != 4'd9) all_nines = 1'b0;
            if (digit != 4'd0) all_zero  = 1'b0;
            if (carry) begin
                if (digit == 4'd9) begin
                    inc_val[4*i +: 4] = 4'd0;
                end else begin
                    inc_val[4*i +: 4] = digit + 4'd1;
                    carry = 1'b0;
                end
            end
            if (borrow) begin
                if (digit == 4'd0) begin
                    dec_val[4*i +: 4] = 4'd9;
                end else begin
                    dec_val[4*i +: 4] = digit - 4'd1;
                    borrow = 1'b0;
                end
            end
            if (bus.load_val[4*i +: 4] > 4'd9) load_ok = 1'b0;
        end
    end

    // Count register with load > enable > hold priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q    <= '0;
            wrap_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else if (bus.load) begin
            wrap_q <= 1'b0;
            if (load_ok) begin
                count_q    <= bus.load_val;
                load_err_q <= 1'b0;
            end else begin
                load_err_q <= 1'b1;
            end
        end else if (bus.en) begin
            load_err_q <= 1'b0;
            if (bus.up) begin
                count_q <= inc_val;
                wrap_q  <= all_nines;
            end else begin
                count_q <= dec_val;
                wrap_q  <= all_zero;
            end
        end else begin
            wrap_q     <= 1'b0;
            load_err_q <= 1'b0;
        end
    end

    assign bus.count    = count_q;
    assign bus.wrap     = wrap_q;
    assign bus.load_err = load_err_q;
    assign bus.tc       = bus.en & ~bus.load & (bus.up ? all_nines : all_zero);
endmodule

// File: tb/tb_bcd_counter.sv
// Directed bench for a 2-digit bcd_counter.
module tb_bcd_counter;
    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;
    int   wraps;

    bcd_counter_if #(.DIGITS(2)) bus ();

    bcd_counter #(.DIGITS(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] to_bcd(input int n);
        logic [7:0] r;
        r[7:4] = 4'((n % 100) / 10);
        r[3:0] = 4'(n % 10);
        return r;
    endfunction

    initial begin
        vectors     = 0;
        miscompares = 0;
        wraps       = 0;
        rst_n        = 1'b0;
        bus.en       = 1'b0;
        bus.up       = 1'b1;
        bus.load     = 1'b0;
        bus.load_val = '0;

        // Reset state
        step();
        step();
        check("rst_count", 32'(bus.count), 32'h00);
        check("rst_wrap", 32'(bus.wrap), 32'h0);
        check("rst_lerr", 32'(bus.load_err), 32'h0);
        #2 rst_n = 1'b1;

        // Asynchronous reset mid-count at 37
        bus.load = 1'b1; bus.load_val = 8'h36;
        step();
        bus.load = 1'b0; bus.en = 1'b1; bus.up = 1'b1;
        step();
        check("pre_rst_37", 32'(bus.count), 32'h37);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_count", 32'(bus.count), 32'h00);
        check("async_rst_wrap", 32'(bus.wrap), 32'h0);
        check("async_rst_lerr", 32'(bus.load_err), 32'h0);
        bus.en = 1'b0;
        #3 rst_n = 1'b1;
        step();
        step();
        check("post_rst_hold", 32'(bus.count), 32'h00);

        // Up-count through wrap
        bus.load = 1'b1; bus.load_val = 8'h97;
        step();
        bus.load = 1'b0;
        check("load_97", 32'(bus.count), 32'h97);
        check("tc_idle", 32'(bus.tc), 32'h0);
        bus.en = 1'b1; bus.up = 1'b1;
        #1 check("tc_97", 32'(bus.tc), 32'h0);
        step();
        check("up_98", 32'(bus.count), 32'h98);
        check("up_98_wrap", 32'(bus.wrap), 32'h0);
        check("tc_98", 32'(bus.tc), 32'h0);
        step();
        check("up_99", 32'(bus.count), 32'h99);
        check("up_99_wrap", 32'(bus.wrap), 32'h0);
        check("tc_99", 32'(bus.tc), 32'h1);
        step();
        check("up_00", 32'(bus.count), 32'h00);
        check("up_00_wrap", 32'(bus.wrap), 32'h1);
        check("tc_00_up", 32'(bus.tc), 32'h0);
        bus.en = 1'b0;
        step();
        check("hold_wrap_clr", 32'(bus.wrap), 32'h0);
        check("hold_count", 32'(bus.count), 32'h00);

        // Down-count with borrow and underflow wrap
        bus.load = 1'b1; bus.load_val = 8'h10;
        step();
        bus.load = 1'b0; bus.en = 1'b1; bus.up = 1'b0;
        step();
        check("dn_09", 32'(bus.count), 32'h09);
        step();
        check("dn_08", 32'(bus.count), 32'h08);
        step();
        check("dn_07", 32'(bus.count), 32'h07);
        check("dn_07_wrap", 32'(bus.wrap), 32'h0);
        bus.en = 1'b0; bus.load = 1'b1; bus.load_val = 8'h00;
        step();
        bus.load = 1'b0; bus.en = 1'b1; bus.up = 1'b1;
        #1 check("tc_00_dir_up", 32'(bus.tc), 32'h0);
        bus.up = 1'b0;
        #1 check("tc_00_dir_dn", 32'(bus.tc), 32'h1);
        step();
        check("dn_99", 32'(bus.count), 32'h99);
        check("dn_99_wrap", 32'(bus.wrap), 32'h1);
        check("tc_99_dn", 32'(bus.tc), 32'h0);
        bus.en = 1'b0;
        step();

        // Invalid loads are rejected
        bus.load = 1'b1; bus.load_val = 8'h42;
        step();
        check("load_42", 32'(bus.count), 32'h42);
        bus.load_val = 8'h4A;
        step();
        check("bad_4A_count", 32'(bus.count), 32'h42);
        check("bad_4A_lerr", 32'(bus.load_err), 32'h1);
        check("bad_4A_wrap", 32'(bus.wrap), 32'h0);
        bus.load = 1'b0;
        step();
        check("bad_4A_lerr_clr", 32'(bus.load_err), 32'h0);
        bus.load = 1'b1; bus.load_val = 8'hA0;
        step();
        check("bad_A0_count", 32'(bus.count), 32'h42);
        check("bad_A0_lerr", 32'(bus.load_err), 32'h1);
        bus.load_val = 8'h59;
        step();
        check("load_59", 32'(bus.count), 32'h59);
        check("load_59_lerr", 32'(bus.load_err), 32'h0);

        // Load beats enable; tc suppressed during load
        bus.en = 1'b1; bus.up = 1'b1; bus.load_val = 8'h99;
        #1 check("tc_during_load", 32'(bus.tc), 32'h0);
        step();
        check("prio_count", 32'(bus.count), 32'h99);
        check("prio_wrap", 32'(bus.wrap), 32'h0);
        check("tc_load_at_99", 32'(bus.tc), 32'h0);
        bus.load = 1'b0;
        #1 check("tc_after_load", 32'(bus.tc), 32'h1);
        step();
        check("prio_wrap_00", 32'(bus.count), 32'h00);
        check("prio_wrap_pulse", 32'(bus.wrap), 32'h1);

        // Full 100-step sweep from 0
        bus.en = 1'b0; bus.load = 1'b1; bus.load_val = 8'h00;
        step();
        bus.load = 1'b0; bus.en = 1'b1; bus.up = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            step();
            check("sweep_count", 32'(bus.count), 32'(to_bcd(i)));
            check("sweep_digits_ok", 32'((bus.count[3:0] <= 4'd9) && (bus.count[7:4] <= 4'd9)), 32'h1);
            check("sweep_no_overlap", 32'(bus.wrap & bus.load_err), 32'h0);
            if (bus.wrap) wraps++;
        end
        check("sweep_wrap_count", 32'(wraps), 32'd1);
        check("sweep_last_wrap", 32'(bus.wrap), 32'h1);
        bus.en = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/bcd_counter.md
# bcd_counter

Parameterised multi-digit BCD up/down counter that produces the packed 4-bit BCD digits consumed by the BCD-to-one-hot decimal decoder stage. Each 4-bit digit slice of `count` drives one decoder instance directly. The counter never emits a non-BCD code (1010–1111), so downstream decoders never reach their undefined default branch. It supports synchronous parallel load with digit validation, direction control, wrap signalling and a combinational terminal-count output for cascading.

## Interface
- `DIGITS`, default 2: number of BCD digits; legal range 1..8.
- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  asynchronous, active-low reset.
- `en`  input  1  count enable; one step per cycle while high.
- `up`  input  1  direction: 1 = increment, 0 = decrement; sampled only when counting.
- `load`  input  1  synchronous parallel load request.
- `load_val`  input  4*DIGITS  packed BCD load value; digit 0 in [3:0].
- `count`  output  4*DIGITS  registered packed BCD count; digit 0 in [3:0].
- `wrap`  output  1  registered one-cycle pulse, high in the cycle after a wrap step.
- `load_err`  output  1  registered one-cycle pulse, high in the cycle after a rejected load.
- `tc`  output  1  combinational terminal count: `en & ~load & (up ? count==all-9s : count==0)`.

## Operation
- Reset (`rst_n`=0, asynchronous, independent of `clk`): `count`=0, `wrap`=0, `load_err`=0. The counter holds while `rst_n` is low and resumes on the first rising edge after release.
- Per rising edge, the following priority applies: `load` > `en` > hold.
- Load path:
  - If every digit of `load_val` is ≤9: `count` ← `load_val`, `load_err`=0.
  - If any digit is >9: `count` is unchanged and `load_err`=1 for exactly one cycle.
  - `wrap`=0 on any load cycle, and `en` is ignored on that cycle.
- Increment (`en`=1, `up`=1):
  - Digit 0 increases by 1. A digit at 9 goes to 0 and carries into the next digit, ripple style, within one cycle.
  - From all-9s, `count` goes to 0 and `wrap`=1.
- Decrement (`en`=1, `up`=0):
  - Digit 0 decreases by 1. A digit at 0 goes to 9 and borrows from the next digit.
  - From 0, `count` goes to all-9s and `wrap`=1.
- Hold (`en`=0, `load`=0): `count` is unchanged and `wrap`=`load_err`=0.
- `wrap` and `load_err` are never high in the same cycle.
- Digit arithmetic is done per 4-bit slice with an explicit 9/0 compare, not binary add-and-adjust. Every reachable `count` value is valid BCD.
- `tc` is purely combinational from the current inputs and `count`. It is intended to drive the `en` of a higher-order cascaded counter, and it goes low during a load.

## Timing
- Latency: one clock from a sampled `en`/`load` to the updated `count`. `wrap` and `load_err` become valid in the same cycle as the `count` update.
- `tc` is valid in the same cycle as its inputs. It is high exactly in the cycle whose clock edge will produce the wrap.
- Direction change on `up` takes effect on the next enabled edge, with no dead cycle.
- Reset asserted mid-count clears all outputs immediately, with no clock required. `tc` then follows the reset `count` (0).
- Deassertion of `rst_n` is synchronised externally. The block performs no action on the release edge itself.
- All outputs are registered except `tc`.

## Test plan
- Reset: with `DIGITS`=2, assert `rst_n`=0 mid-count at `count`=8'h37 → `count`=8'h00 and `wrap`=`load_err`=0 without a clock edge. After release with `en`=0, `count` stays 8'h00.
- Up-count: load 8'h97, then `en`=1, `up`=1 for 3 cycles → 8'h98, 8'h99, 8'h00. `wrap`=1 only with 8'h00, and `tc`=1 only while `count`=8'h99.
- Down-count: load 8'h10, then `up`=0 for 3 cycles → 8'h09, 8'h08, 8'h07. Load 8'h00 and decrement once → 8'h99 with `wrap`=1. `tc`=1 while `count`=8'h00 and `up`=0.
- Invalid load: from 8'h42, `load`=1 with `load_val`=8'h4A → `count` stays 8'h42, `load_err`=1 for one cycle then 0. Repeat with 8'hA0 for the same result. `load_val`=8'h59 → `count`=8'h59, `load_err`=0.
- Priority: `load`=1, `en`=1, `up`=1, `load_val`=8'h99 → `count`=8'h99, `wrap`=0, `tc`=0 during that cycle. Next cycle `tc`=1, then `count`=8'h00 with `wrap`=1.
- Exhaustive: run `en`=1, `up`=1 for 100 cycles from 0 → each cycle `count` equals the cycle index mod 100 in BCD. No digit ever exceeds 9, and exactly one `wrap` pulse occurs.
